// File: rtl/axis_axi_capture.sv
`default_nettype none
// ============================================================================
// Module   : axis_axi_capture
// Captures one AXI-Stream frame into a block RAM and exposes it read-only
// through an AXI4-Lite slave.
// Revision : 1.0
// ============================================================================
module axis_axi_capture #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 14,
    parameter int DATA_WIDTH     = 24
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic [AXI_ADDR_WIDTH-3:0]   frame_length,
    output logic                        done,
    output logic [AXI_ADDR_WIDTH-2:0]   count,
    input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]                  s_axil_arprot,
    input  logic                        s_axil_arvalid,
    output logic                        s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                  s_axil_rresp,
    output logic                        s_axil_rvalid,
    input  logic                        s_axil_rready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]                  s_axil_awprot,
    input  logic                        s_axil_awvalid,
    output logic                        s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                        s_axil_wvalid,
    output logic                        s_axil_wready,
    output logic [1:0]                  s_axil_bresp,
    output logic                        s_axil_bvalid,
    input  logic                        s_axil_bready
);

    localparam int c_WORD_AW = AXI_ADDR_WIDTH - 2;
    localparam int c_CNT_W   = AXI_ADDR_WIDTH - 1;
    localparam int c_DEPTH   = 1 << c_WORD_AW;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_tready;
    logic                  w_done;
    logic                  w_beat;
    logic [c_WORD_AW-1:0]  r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_ram_q;
    logic                  r_arready;
    logic                  r_rd_pend;
    logic [c_WORD_AW-1:0]  r_rd_addr;
    logic                  r_rvalid;
    logic                  r_wr_rdy;
    logic                  r_bvalid;
    logic                  w_unused;

    assign w_beat = s_axis_tvalid & w_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (enable) w_state_nxt = c_ST_CAPTURE;
            end
            c_ST_CAPTURE: begin
                if (!enable)
                    w_state_nxt = c_ST_IDLE;
                else if (w_beat && ((r_wr_ptr == frame_length) || s_axis_tlast))
                    w_state_nxt = c_ST_DONE;
            end
            c_ST_DONE: begin
                if (!enable) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_tready = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            c_ST_CAPTURE: w_tready = 1'b1;
            c_ST_DONE:    w_done   = 1'b1;
            default: ;
        endcase
    end

    // count survives IDLE so software can read the length of an aborted frame
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (r_state == c_ST_IDLE) begin
            r_wr_ptr <= '0;
            if (enable) r_count <= '0;
        end else if (w_beat) begin
            r_wr_ptr <= r_wr_ptr + c_WORD_AW'(1);
            r_count  <= r_count + c_CNT_W'(1);
        end
    end

    // Buffer has no reset; separate write and read ports give read-first collisions
    always_ff @(posedge aclk) begin
        if (w_beat) r_mem[r_wr_ptr] <= s_axis_tdata;
    end

    always_ff @(posedge aclk) begin
        if (r_rd_pend) r_ram_q <= r_mem[r_rd_addr];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_arready <= 1'b0;
            r_rd_pend <= 1'b0;
            r_rd_addr <= '0;
            r_rvalid  <= 1'b0;
        end else begin
            r_rd_pend <= 1'b0;
            if (s_axil_arvalid && r_arready) begin
                r_arready <= 1'b0;
                r_rd_pend <= 1'b1;
                r_rd_addr <= s_axil_araddr[AXI_ADDR_WIDTH-1:2];
            end else if ((r_rvalid && s_axil_rready) || (!r_rd_pend && !r_rvalid)) begin
                r_arready <= 1'b1;
            end
            if (r_rd_pend)
                r_rvalid <= 1'b1;
            else if (r_rvalid && s_axil_rready)
                r_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_rdy <= 1'b0;
            r_bvalid <= 1'b0;
        end else begin
            r_wr_rdy <= s_axil_awvalid & s_axil_wvalid & ~r_bvalid & ~r_wr_rdy;
            if (r_wr_rdy && s_axil_awvalid && s_axil_wvalid)
                r_bvalid <= 1'b1;
            else if (r_bvalid && s_axil_bready)
                r_bvalid <= 1'b0;
        end
    end

    assign s_axis_tready  = w_tready;
    assign done           = w_done;
    assign count          = r_count;
    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rvalid ? AXI_DATA_WIDTH'(r_ram_q) : '0;
    assign s_axil_rresp   = c_RESP_OKAY;
    assign s_axil_awready = r_wr_rdy;
    assign s_axil_wready  = r_wr_rdy;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bvalid ? c_RESP_SLVERR : c_RESP_OKAY;

    // Write-channel payload and protection bits have no effect on a read-only buffer
    assign w_unused = ^{s_axil_arprot, s_axil_awprot, s_axil_awaddr, s_axil_wdata,
                        s_axil_wstrb, s_axil_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axis_axi_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_axi_capture
// Randomized self-checking bench for axis_axi_capture against a word-array model.
// Revision : 1.0
// ============================================================================
module tb_axis_axi_capture;

    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [11:0] frame_length;
    logic        done;
    logic [12:0] count;
    logic [23:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [13:0] s_axil_araddr;
    logic [2:0]  s_axil_arprot;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [13:0] s_axil_awaddr;
    logic [2:0]  s_axil_awprot;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;

    int          n_checks;
    int          n_errors;
    logic [23:0] m_mem [4096];
    bit          m_known [4096];
    int          m_count;
    int          g_wr_idx;
    bit          g_stream_done;

    axis_axi_capture #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(14),
        .DATA_WIDTH    (24)
    ) u_dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .enable        (enable),
        .frame_length  (frame_length),
        .done          (done),
        .count         (count),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .s_axil_araddr (s_axil_araddr),
        .s_axil_arprot (s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata  (s_axil_rdata),
        .s_axil_rresp  (s_axil_rresp),
        .s_axil_rvalid (s_axil_rvalid),
        .s_axil_rready (s_axil_rready),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awprot (s_axil_awprot),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_val({tag, "_strm"}, {s_axis_tready, done, count}, 0);
        check_val({tag, "_rd"}, {s_axil_arready, s_axil_rvalid, s_axil_rresp}, 0);
        check_val({tag, "_rdata"}, s_axil_rdata, 0);
        check_val({tag, "_wr"}, {s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_bresp}, 0);
    endtask

    task automatic go_idle;
        enable        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        tick;
        check_val("idle_state", {s_axis_tready, done}, 2'b00);
        check_val("idle_count", count, m_count);
    endtask

    // Frame ends after frame_length+1 beats or on the first tlast beat
    task automatic run_frame(input int flen, input int tlast_beat, input int gap_pct,
                             input bit rand_data, output int ncyc);
        int beats = 0;
        int cyc = 0;
        bit fin = 0;
        logic [23:0] d;
        frame_length = 12'(flen);
        enable = 1'b1;
        g_wr_idx = 0;
        tick;
        check_val("cnt_clr", count, 0);
        while (!fin && cyc < 6000) begin
            check_val("rdy_cap", {s_axis_tready, done}, 2'b10);
            s_axis_tvalid = ($urandom_range(0, 99) >= gap_pct);
            d = rand_data ? 24'($urandom) : 24'(beats + 1);
            s_axis_tdata = d;
            s_axis_tlast = (beats + 1 == tlast_beat);
            if (s_axis_tvalid) begin
                m_mem[beats]   = d;
                m_known[beats] = 1'b1;
                beats++;
                g_wr_idx = beats;
                if (beats == flen + 1 || s_axis_tlast) fin = 1'b1;
            end
            tick;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        check_val("frame_end", fin, 1);
        check_val("done_set", {s_axis_tready, done}, 2'b01);
        check_val("count", count, beats);
        m_count = beats;
        ncyc = cyc;
    endtask

    // Expected data is the model word as it stood at the AR handshake edge
    task automatic axi_read(input logic [11:0] wa, input bit bp);
        int n = 0;
        int stall;
        logic [31:0] exp;
        bit kn;
        s_axil_araddr  = {wa, 2'b00};
        s_axil_arvalid = 1'b1;
        while (!s_axil_arready && n < 50) begin
            tick;
            n++;
        end
        check_val("ar_accept", s_axil_arready, 1);
        @(posedge aclk);
        exp = 32'(m_mem[wa]);
        kn  = m_known[wa];
        #1;
        s_axil_arvalid = 1'b0;
        check_val("r_lat1", {s_axil_rvalid, s_axil_arready}, 2'b00);
        tick;
        check_val("r_valid", {s_axil_rvalid, s_axil_rresp}, 3'b100);
        if (kn) check_val("r_data", s_axil_rdata, exp);
        stall = bp ? $urandom_range(0, 3) : 0;
        for (int i = 0; i < stall; i++) begin
            tick;
            check_val("r_hold", s_axil_rvalid, 1);
            if (kn) check_val("r_hold_data", s_axil_rdata, exp);
        end
        s_axil_rready = 1'b1;
        tick;
        s_axil_rready = 1'b0;
        check_val("r_done", {s_axil_rvalid, s_axil_arready}, 2'b01);
    endtask

    task automatic axi_write_start;
        int n = 0;
        s_axil_awaddr  = 14'h0004;
        s_axil_wdata   = 32'hDEADBEEF;
        s_axil_wstrb   = 4'hF;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        while (!(s_axil_awready && s_axil_wready) && n < 20) begin
            tick;
            n++;
        end
        check_val("aw_accept", {s_axil_awready, s_axil_wready}, 2'b11);
        tick;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        check_val("b_resp", {s_axil_bvalid, s_axil_bresp, s_axil_awready}, 4'b1100);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d;
        int ncyc;
        logic [11:0] a;
        n_checks = 0;
        n_errors = 0;
        m_count = 0;
        g_wr_idx = 0;
        g_stream_done = 1'b0;
        for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;
        aresetn = 1'b0; enable = 1'b0; frame_length = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        s_axil_araddr = '0; s_axil_arprot = '0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b0;
        s_axil_awaddr = '0; s_axil_awprot = '0; s_axil_awvalid = 1'b0;
        s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b0;

        #12;
        check_reset("por");
        #10;
        aresetn = 1'b1;
        tick;
        tick;
        check_val("post_rst", {s_axil_arready, s_axis_tready, done}, 3'b100);

        // Back-to-back 8-word frame with sequential data
        run_frame(7, 0, 0, 1'b0, ncyc);
        check_val("b2b_cycles", ncyc, 8);
        for (int i = 0; i < 8; i++) axi_read(12'(i), 1'b0);

        // Fill 0..63, then recapture with concurrent reads and backpressure
        go_idle;
        run_frame(63, 0, 30, 1'b1, ncyc);
        go_idle;
        g_stream_done = 1'b0;
        fork
            begin
                run_frame(63, 0, 30, 1'b1, ncyc);
                g_stream_done = 1'b1;
            end
            begin
                while (!g_stream_done) begin
                    case ($urandom_range(0, 2))
                        0:       a = 12'(g_wr_idx);
                        1:       a = 12'(g_wr_idx + 1);
                        default: a = 12'($urandom_range(0, 63));
                    endcase
                    axi_read(a, 1'b1);
                end
            end
        join

        // tlast on beat 5 ends the frame early; the 6th word is refused
        go_idle;
        run_frame(15, 5, 0, 1'b1, ncyc);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 24'hABCDEF;
        tick;
        s_axis_tvalid = 1'b0;
        check_val("no_6th", {count, s_axis_tready, done}, {13'd5, 2'b01});
        axi_read(12'd5, 1'b0);

        // Write attempt is rejected and leaves memory unchanged
        axi_write_start;
        tick;
        check_val("b_held", {s_axil_bvalid, s_axil_bresp}, 3'b110);
        s_axil_bready = 1'b1;
        tick;
        s_axil_bready = 1'b0;
        check_val("b_clear", s_axil_bvalid, 0);
        axi_read(12'd1, 1'b0);

        // Abort after 3 beats, then re-enable
        go_idle;
        frame_length = 12'd15;
        enable = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            d = 24'($urandom);
            s_axis_tdata = d; s_axis_tvalid = 1'b1;
            m_mem[i] = d; m_known[i] = 1'b1;
            tick;
        end
        s_axis_tvalid = 1'b0;
        enable = 1'b0;
        tick;
        check_val("drop_state", {s_axis_tready, done}, 2'b00);
        check_val("drop_count", count, 3);
        enable = 1'b1;
        tick;
        check_val("reen_state", {count, s_axis_tready}, {13'd0, 1'b1});
        d = 24'($urandom);
        s_axis_tdata = d; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1;
        m_mem[0] = d;
        tick;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        check_val("reen_done", {count, done}, {13'd1, 1'b1});
        m_count = 1;
        axi_read(12'd0, 1'b0);
        axi_read(12'd2, 1'b0);

        // frame_length all-ones fills the whole buffer
        go_idle;
        run_frame(4095, 0, 0, 1'b1, ncyc);
        axi_read(12'd4095, 1'b0);
        axi_read(12'd0, 1'b0);

        // Reset mid-frame with a read and a write response in flight
        go_idle;
        frame_length = 12'd15;
        enable = 1'b1;
        tick;
        for (int i = 0; i < 2; i++) begin
            d = 24'($urandom);
            s_axis_tdata = d; s_axis_tvalid = 1'b1;
            m_mem[i] = d; m_known[i] = 1'b1;
            tick;
        end
        s_axis_tvalid = 1'b0;
        axi_write_start;
        s_axil_araddr = '0;
        s_axil_arvalid = 1'b1;
        tick;
        s_axil_arvalid = 1'b0;
        tick;
        check_val("rst_pre", {s_axil_rvalid, s_axil_bvalid, s_axis_tready}, 3'b111);
        #3;
        aresetn = 1'b0;
        #1;
        check_reset("rst_async");
        enable = 1'b0;
        @(posedge aclk);
        #3;
        aresetn = 1'b1;
        tick;
        tick;
        check_val("rst_idle", {s_axis_tready, done, s_axil_arready, s_axil_rvalid}, 4'b0010);
        m_count = 0;
        axi_read(12'd0, 1'b0);
        axi_read(12'd1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
